// File: rtl/wb_port_arbiter_pkg.sv
// Shared CPU constants and helpers for the writeback arbiter and its scoreboard.
package wb_port_arbiter_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int NREGS  = 32;

   typedef enum logic [1:0] {
      WIN_NONE = 2'd0,
      WIN_A    = 2'd1,
      WIN_B    = 2'd2
   } win_e;

   function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
      reg_onehot = {{(NREGS-1){1'b0}}, 1'b1} << r;
   endfunction

endpackage

// File: rtl/wb_port_arbiter_scoreboard.sv
// Busy-register scoreboard: long-latency issues mark rd busy, B completions release it.
module wb_scoreboard
   import wb_port_arbiter_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              set_i,
   input  logic [REG_AW-1:0] set_rd_i,
   input  logic              clr_i,
   input  logic [REG_AW-1:0] clr_rd_i,
   input  logic [REG_AW-1:0] rs1_i,
   input  logic [REG_AW-1:0] rs2_i,
   output logic              hazard_o
);

   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic [NREGS-1:0] set_vec_s;
   logic [NREGS-1:0] clr_vec_s;

   // Next busy vector; a set applied after the clear so a same-cycle set wins.
   always_comb begin
      set_vec_s = {NREGS{1'b0}};
      clr_vec_s = {NREGS{1'b0}};
      if (set_i) begin
         set_vec_s = reg_onehot(set_rd_i);
      end else begin
         set_vec_s = {NREGS{1'b0}};
      end
      if (clr_i) begin
         clr_vec_s = reg_onehot(clr_rd_i);
      end else begin
         clr_vec_s = {NREGS{1'b0}};
      end
      busy_d    = (busy_q & ~clr_vec_s) | set_vec_s;
      busy_d[0] = 1'b0;
   end

   // Busy vector register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= {NREGS{1'b0}};
      end else begin
         busy_q <= busy_d;
      end
   end

   // Operand lookup uses only the registered vector: no same-cycle bypass.
   always_comb begin
      hazard_o = ((rs1_i != {REG_AW{1'b0}}) & busy_q[rs1_i])
               | ((rs2_i != {REG_AW{1'b0}}) & busy_q[rs2_i]);
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Two-requester register-file write port arbiter with starvation guard for B
// and a busy scoreboard for long-latency destinations.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 4
)(
   input  logic              clk_regs,
   input  logic              rst,
   input  logic              a_valid,
   input  logic [REG_AW-1:0] a_rd,
   input  logic [XLEN-1:0]   a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [REG_AW-1:0] b_rd,
   input  logic [XLEN-1:0]   b_data,
   output logic              b_ready,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_rd,
   input  logic              iss_long,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   output logic              hazard,
   output logic [XLEN-1:0]   rf_din,
   output logic [REG_AW-1:0] rf_rd,
   output logic              rf_wrt
);

   localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic [XLEN-1:0]   rf_din_q, rf_din_d;
   logic [REG_AW-1:0] rf_rd_q, rf_rd_d;
   logic              rf_wrt_q, rf_wrt_d;
   logic              starved_s;
   logic              a_xfer_s;
   logic              b_xfer_s;
   win_e              win_s;

   // Grant: A has priority unless B has been refused STARVE_MAX times.
   always_comb begin
      starved_s = (starve_cnt_q == STARVE_LIM);
      if (starved_s) begin
         a_ready = 1'b0;
         b_ready = 1'b1;
      end else begin
         a_ready = 1'b1;
         b_ready = ~a_valid;
      end
      a_xfer_s = a_valid & a_ready;
      b_xfer_s = b_valid & b_ready;
   end

   // Starvation counter next state; held while B is idle.
   always_comb begin
      if (b_xfer_s) begin
         starve_cnt_d = {CNT_W{1'b0}};
      end else if (b_valid && !b_ready && !starved_s) begin
         starve_cnt_d = starve_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         starve_cnt_d = starve_cnt_q;
      end
   end

   // Winner selection and register-file write next state; rd 0 never writes.
   always_comb begin
      win_s    = WIN_NONE;
      rf_din_d = rf_din_q;
      rf_rd_d  = rf_rd_q;
      rf_wrt_d = 1'b0;
      if (a_xfer_s) begin
         win_s = WIN_A;
      end else if (b_xfer_s) begin
         win_s = WIN_B;
      end else begin
         win_s = WIN_NONE;
      end
      case (win_s)
         WIN_A: begin
            rf_din_d = a_data;
            rf_rd_d  = a_rd;
            rf_wrt_d = (a_rd != {REG_AW{1'b0}});
         end
         WIN_B: begin
            rf_din_d = b_data;
            rf_rd_d  = b_rd;
            rf_wrt_d = (b_rd != {REG_AW{1'b0}});
         end
         default: begin
            rf_din_d = rf_din_q;
            rf_rd_d  = rf_rd_q;
            rf_wrt_d = 1'b0;
         end
      endcase
   end

   // State registers.
   always_ff @(posedge clk_regs or negedge rst) begin
      if (!rst) begin
         starve_cnt_q <= {CNT_W{1'b0}};
         rf_din_q     <= {XLEN{1'b0}};
         rf_rd_q      <= {REG_AW{1'b0}};
         rf_wrt_q     <= 1'b0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         rf_din_q     <= rf_din_d;
         rf_rd_q      <= rf_rd_d;
         rf_wrt_q     <= rf_wrt_d;
      end
   end

   assign rf_din = rf_din_q;
   assign rf_rd  = rf_rd_q;
   assign rf_wrt = rf_wrt_q;

   wb_scoreboard u_scoreboard (
      .clk_i    (clk_regs),
      .rst_ni   (rst),
      .set_i    (iss_valid & iss_long),
      .set_rd_i (iss_rd),
      .clr_i    (b_xfer_s),
      .clr_rd_i (b_rd),
      .rs1_i    (rs1),
      .rs2_i    (rs2),
      .hazard_o (hazard)
   );

endmodule
